// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the LC-3b two-port memory arbiter: FSM state, port
// identifiers, memory operation and the latched request word.
// No ports (package).

package mem_arbiter_pkg;

  // The latched request word is fixed at the LC-3b bus widths.
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_A,
    ARB_SERVE_B
  } arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } arb_port_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  typedef struct packed {
    mem_op_t                 op;
    logic [1:0]              wmask;
    logic [MEM_ADDR_W-1:0]   address;
    logic [MEM_DATA_W-1:0]   wdata;
  } lc3b_mem_req;

  // Round-robin helper: the port that did not win last time.
  function automatic arb_port_t other_port(input arb_port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port (A), the MEM-stage data port (B) and the physical
// memory port into one interface.
//   modport slave  : arbiter view (drives resp/rdata back to the requesters
//                    and the pmem_* strobes/address/data out to memory)
//   modport master : environment view (requesters plus physical memory)
// Parameters: ADDR_W address width, DATA_W data width.

interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // fetch port
  logic              read_a;
  logic [ADDR_W-1:0] address_a;
  logic              resp_a;
  logic [DATA_W-1:0] rdata_a;

  // data port
  logic              read_b;
  logic              write_b;
  logic [1:0]        wmask_b;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] wdata_b;
  logic              resp_b;
  logic [DATA_W-1:0] rdata_b;

  // physical memory
  logic              pmem_read;
  logic              pmem_write;
  logic [1:0]        pmem_wmask;
  logic [ADDR_W-1:0] pmem_address;
  logic [DATA_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [DATA_W-1:0] pmem_rdata;

  modport slave (
    input  read_a, address_a,
    output resp_a, rdata_a,
    input  read_b, write_b, wmask_b, address_b, wdata_b,
    output resp_b, rdata_b,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output read_a, address_a,
    input  resp_a, rdata_a,
    output read_b, write_b, wmask_b, address_b, wdata_b,
    input  resp_b, rdata_b,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/mem_arbiter_reg.sv
// mem_arbiter_reg
// Generic load-enabled register with asynchronous active-low clear.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low clear
//   load     in   capture d on the next rising edge
//   d        in   WIDTH-bit data in
//   q        out  WIDTH-bit registered data

module mem_arbiter_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one physical memory between the instruction-fetch port (A) and the
// data-access port (B). Grants are round-robin under contention, the winning
// request is latched and held on pmem_* until pmem_resp, and the response is
// routed combinationally back to the granted port.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of mem_arbiter_if (ports A, B and pmem)
//
// state        | meaning
// -------------+-----------------------------------------------
// ARB_IDLE     | nothing driven to pmem, waiting for a request
// ARB_SERVE_A  | fetch transaction outstanding on pmem
// ARB_SERVE_B  | data transaction outstanding on pmem

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  arb_state_t  state_q, state_d;
  arb_port_t   last_grant_q, last_grant_d;
  lc3b_mem_req req_q, req_d;
  logic        req_a, req_b;
  logic        req_load;
  logic        busy;

  assign req_a = bus.read_a;
  assign req_b = bus.read_b | bus.write_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= PORT_B;   // first contested grant goes to A
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (req_a && req_b) begin
          last_grant_d = other_port(last_grant_q);
          state_d      = (last_grant_d == PORT_A) ? ARB_SERVE_A : ARB_SERVE_B;
        end else if (req_a) begin
          last_grant_d = PORT_A;
          state_d      = ARB_SERVE_A;
        end else if (req_b) begin
          last_grant_d = PORT_B;
          state_d      = ARB_SERVE_B;
        end
      end
      ARB_SERVE_A,
      ARB_SERVE_B: begin
        // Dropped requests do not abort; only pmem_resp ends a transaction.
        if (bus.pmem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request word for the winner. Fetches are always full-word reads with no
  // store data; a data request with both strobes set is treated as a write.
  always_comb begin
    req_d = '0;
    if (state_d == ARB_SERVE_A) begin
      req_d.op      = OP_READ;
      req_d.wmask   = 2'b11;
      req_d.address = bus.address_a;
      req_d.wdata   = '0;
    end else begin
      req_d.op      = bus.write_b ? OP_WRITE : OP_READ;
      req_d.wmask   = bus.wmask_b;
      req_d.address = bus.address_b;
      req_d.wdata   = bus.wdata_b;
    end
  end

  assign req_load = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);

  mem_arbiter_reg #(
    .WIDTH($bits(lc3b_mem_req))
  ) u_req_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (req_load),
    .d       (req_d),
    .q       (req_q)
  );

  // All pmem outputs are decoded from flops only, so they hold steady for the
  // whole SERVE state and collapse the instant reset is asserted.
  assign busy             = (state_q != ARB_IDLE);
  assign bus.pmem_read    = busy && (req_q.op == OP_READ);
  assign bus.pmem_write   = busy && (req_q.op == OP_WRITE);
  assign bus.pmem_wmask   = busy ? req_q.wmask   : 2'b00;
  assign bus.pmem_address = busy ? req_q.address : {ADDR_W{1'b0}};
  assign bus.pmem_wdata   = busy ? req_q.wdata   : {DATA_W{1'b0}};

  assign bus.resp_a  = (state_q == ARB_SERVE_A) && bus.pmem_resp;
  assign bus.resp_b  = (state_q == ARB_SERVE_B) && bus.pmem_resp;
  assign bus.rdata_a = bus.resp_a ? bus.pmem_rdata : {DATA_W{1'b0}};
  assign bus.rdata_b = bus.resp_b ? bus.pmem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Transaction-level reference: who owns memory (0 none, 1 A, 2 B), who won
  // last, and the transaction being served.
  int          owner;
  int          last;
  logic        t_write;
  logic [1:0]  t_mask;
  logic [15:0] t_addr;
  logic [15:0] t_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner   = 0;
    last    = 2;
    t_write = 1'b0;
    t_mask  = 2'b00;
    t_addr  = 16'h0;
    t_wdata = 16'h0;
  endtask

  task automatic model_edge();
    bit ra, rb;
    int pick;
    if (owner != 0) begin
      if (bus.pmem_resp) owner = 0;
    end else begin
      ra = bus.read_a;
      rb = bus.read_b | bus.write_b;
      pick = 0;
      if (ra && rb) pick = 3 - last;
      else if (ra)  pick = 1;
      else if (rb)  pick = 2;
      if (pick == 1) begin
        t_write = 1'b0; t_mask = 2'b11; t_addr = bus.address_a; t_wdata = 16'h0;
      end else if (pick == 2) begin
        t_write = bus.write_b; t_mask = bus.wmask_b;
        t_addr = bus.address_b; t_wdata = bus.wdata_b;
      end
      if (pick != 0) begin
        owner = pick;
        last  = pick;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic ea, eb;
    ea = (owner == 1) && bus.pmem_resp;
    eb = (owner == 2) && bus.pmem_resp;
    chk({tag, ".pmem_read"},    32'(bus.pmem_read),    32'((owner != 0) && !t_write));
    chk({tag, ".pmem_write"},   32'(bus.pmem_write),   32'((owner != 0) && t_write));
    chk({tag, ".pmem_wmask"},   32'(bus.pmem_wmask),   32'((owner != 0) ? t_mask : 2'b00));
    chk({tag, ".pmem_address"}, 32'(bus.pmem_address), 32'((owner != 0) ? t_addr : 16'h0));
    chk({tag, ".pmem_wdata"},   32'(bus.pmem_wdata),   32'((owner != 0) ? t_wdata : 16'h0));
    chk({tag, ".resp_a"},       32'(bus.resp_a),       32'(ea));
    chk({tag, ".rdata_a"},      32'(bus.rdata_a),      32'(ea ? bus.pmem_rdata : 16'h0));
    chk({tag, ".resp_b"},       32'(bus.resp_b),       32'(eb));
    chk({tag, ".rdata_b"},      32'(bus.rdata_b),      32'(eb ? bus.pmem_rdata : 16'h0));
  endtask

  // Check the current cycle, then advance one clock (model follows the edge).
  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.read_a     = 1'b0;
    bus.address_a  = 16'h0;
    bus.read_b     = 1'b0;
    bus.write_b    = 1'b0;
    bus.wmask_b    = 2'b00;
    bus.address_b  = 16'h0;
    bus.wdata_b    = 16'h0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0;
  endtask

  logic [15:0] ct_addr [4];

  initial begin
    // reset with a fetch pending
    idle_inputs();
    bus.read_a    = 1'b1;
    bus.address_a = 16'h0010;
    reset_n       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("rst");
    chk("rst.pmem_read_low", 32'(bus.pmem_read), 32'd0);
    reset_n = 1'b1;
    cyc("rst_release");
    #1;
    chk("rst.first_read", 32'(bus.pmem_read), 32'd1);
    chk("rst.first_addr", 32'(bus.pmem_address), 32'h0010);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h5A5A;
    cyc("rst_resp");
    idle_inputs();
    cyc("rst_idle");

    // lone fetch, memory answers in the third strobe cycle
    bus.read_a    = 1'b1;
    bus.address_a = 16'h0020;
    cyc("lf_req");
    cyc("lf_wait1");
    cyc("lf_wait2");
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h1234;
    #1;
    chk("lf.resp_a", 32'(bus.resp_a), 32'd1);
    chk("lf.rdata_a", 32'(bus.rdata_a), 32'h1234);
    cyc("lf_resp");
    idle_inputs();
    #1;
    chk("lf.read_after", 32'(bus.pmem_read), 32'd0);
    cyc("lf_idle");

    // store on port B
    bus.write_b   = 1'b1;
    bus.wmask_b   = 2'b10;
    bus.address_b = 16'h0101;
    bus.wdata_b   = 16'hAB00;
    cyc("st_req");
    #1;
    chk("st.pmem_write", 32'(bus.pmem_write), 32'd1);
    chk("st.pmem_wmask", 32'(bus.pmem_wmask), 32'h2);
    chk("st.pmem_wdata", 32'(bus.pmem_wdata), 32'hAB00);
    bus.pmem_resp = 1'b1;
    #1;
    chk("st.resp_b", 32'(bus.resp_b), 32'd1);
    cyc("st_resp");
    idle_inputs();
    cyc("st_idle");

    // contention straight after reset: A, B, A, B
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n       = 1'b1;
    bus.read_a    = 1'b1;
    bus.address_a = 16'h0A00;
    bus.read_b    = 1'b1;
    bus.address_b = 16'h0B00;
    ct_addr[0] = 16'h0A00; ct_addr[1] = 16'h0B00;
    ct_addr[2] = 16'h0A00; ct_addr[3] = 16'h0B00;
    for (int i = 0; i < 4; i++) begin
      bus.pmem_resp = 1'b0;
      #1;
      chk("ct.idle_gap", 32'(bus.pmem_read), 32'd0);
      cyc("ct_idle");
      #1;
      chk("ct.grant_addr", 32'(bus.pmem_address), 32'(ct_addr[i]));
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = 16'(i + 16'h0100);
      cyc("ct_resp");
    end
    idle_inputs();
    cyc("ct_end");

    // requester abandons a read, then a stray response while idle
    bus.read_b    = 1'b1;
    bus.address_b = 16'h0300;
    cyc("ab_req");
    bus.read_b = 1'b0;
    cyc("ab_drop");
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'hBEEF;
    #1;
    chk("ab.resp_b", 32'(bus.resp_b), 32'd1);
    cyc("ab_resp");
    #1;
    chk("ab.stray_resp_a", 32'(bus.resp_a), 32'd0);
    chk("ab.stray_resp_b", 32'(bus.resp_b), 32'd0);
    cyc("ab_stray");
    bus.pmem_resp = 1'b0;
    cyc("ab_idle");

    // reset in the middle of a store
    bus.write_b   = 1'b1;
    bus.wmask_b   = 2'b11;
    bus.address_b = 16'h0444;
    bus.wdata_b   = 16'h7777;
    cyc("rs_req");
    #1;
    chk("rs.write_before", 32'(bus.pmem_write), 32'd1);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rs.write_async", 32'(bus.pmem_write), 32'd0);
    check_all("rs_inreset");
    @(negedge clk);
    reset_n       = 1'b1;
    bus.read_a    = 1'b1;
    bus.address_a = 16'h0555;
    bus.pmem_resp = 1'b1;   // late response from the aborted store
    #1;
    chk("rs.late_resp_b", 32'(bus.resp_b), 32'd0);
    cyc("rs_late");
    bus.pmem_resp = 1'b0;
    #1;
    chk("rs.regrant_addr", 32'(bus.pmem_address), 32'h0555);
    chk("rs.regrant_read", 32'(bus.pmem_read), 32'd1);
    bus.pmem_resp = 1'b1;
    cyc("rs_resp");
    idle_inputs();
    cyc("rs_idle");

    // randomized traffic against the reference
    for (int n = 0; n < 600; n++) begin
      bus.read_a     = ($urandom_range(0, 2) != 0);
      bus.address_a  = 16'($urandom);
      bus.read_b     = ($urandom_range(0, 2) == 0);
      bus.write_b    = ($urandom_range(0, 3) == 0);
      bus.wmask_b    = 2'($urandom);
      bus.address_b  = 16'($urandom);
      bus.wdata_b    = 16'($urandom);
      bus.pmem_resp  = ($urandom_range(0, 2) == 0);
      bus.pmem_rdata = 16'($urandom);
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
